// File: rtl/seq_detector_param_if.sv
// Serial-bit and pattern-control bundle for seq_detector_param; match_cnt exists only with SEQ_DET_MATCH_CNT_EN.
// master = bit source / controller, slave = detector.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 7,
  parameter int CNT_W   = 8
);
  logic               x;
  logic               in_valid;
  logic               overlap;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               z;
  logic               z_q;
  logic [PAT_LEN-1:0] pattern;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  modport master (
    output x, in_valid, overlap, pat_load, pat_in,
`ifdef SEQ_DET_MATCH_CNT_EN
    input  match_cnt,
`endif
    input  z, z_q, pattern
  );

  modport slave (
    input  x, in_valid, overlap, pat_load, pat_in,
`ifdef SEQ_DET_MATCH_CNT_EN
    output match_cnt,
`endif
    output z, z_q, pattern
  );
endinterface

// File: rtl/seq_detector_param.sv
// Mealy PAT_LEN-bit sequence detector, runtime overlap mode and reloadable pattern; SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
// Latency: z same cycle as the last pattern bit, z_q one cycle later.
// Backpressure: none; in_valid qualifies bits, idle cycles simply hold state.
module seq_detector_param #(
  parameter int                 PAT_LEN  = 7,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 7'b1111001,
  parameter int                 CNT_W    = 8
) (
  input logic                clk,
  input logic                rst,
  seq_detector_param_if.slave bus
);
  localparam int            FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] pat_r;
  logic [PAT_LEN-1:0] window;
  logic               z_q_r;
  logic               match;

  // window is the candidate sequence including the bit on the wire this cycle
  assign window = {hist, bus.x};
  assign match  = bus.in_valid & (fill == FILL_MAX) & (window == pat_r)
                & ~bus.pat_load & ~rst;

  assign bus.z       = match;
  assign bus.z_q     = z_q_r;
  assign bus.pattern = pat_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      fill  <= '0;
      pat_r <= PAT_INIT;
      z_q_r <= 1'b0;
    end else if (bus.pat_load) begin
      pat_r <= bus.pat_in;
      hist  <= '0;
      fill  <= '0;
      z_q_r <= 1'b0;
    end else begin
      z_q_r <= match;
      if (bus.in_valid) begin
        if (match && !bus.overlap) begin
          // non-overlapping: matched bits must not seed the next match
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[PAT_LEN-2:0];
          if (fill != FILL_MAX) fill <= fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  assign bus.match_cnt = cnt_r;

  always_ff @(posedge clk) begin
    if (rst || bus.pat_load) begin
      cnt_r <= '0;
    end else if (match && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: z checked before each edge, z_q via an expectation queue after it.
module tb_seq_detector_param;
  localparam int PL = 7;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_LEN(PL), .CNT_W(CW)) bus ();

  seq_detector_param #(.PAT_LEN(PL), .PAT_INIT(7'b1111001), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_pat(input string tag, input logic [PL-1:0] got, input logic [PL-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, check z, queue z_q expectation, check z_q after the edge
  task automatic step(input logic r, input logic vi, input logic xi, input logic ld,
                      input logic [PL-1:0] pi, input logic ez, input string tag);
    logic e;
    @(negedge clk);
    rst = r; bus.in_valid = vi; bus.x = xi; bus.pat_load = ld; bus.pat_in = pi;
    #1;
    chk_bit({tag, ".z"}, bus.z, ez);
    exp_q.push_back(ez);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk_bit({tag, ".q_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk_bit({tag, ".z_q"}, bus.z_q, e);
    end
  endtask

  // feed a bit string MSB first; hits is a bitmask (bit i-1 set => match on bit i)
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] hits, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, bits[n-1-i], 1'b0, '0, hits[i], $sformatf("%s[%0d]", tag, i + 1));
    end
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1; bus.x = 1'b0; bus.in_valid = 1'b0; bus.overlap = 1'b1;
    bus.pat_load = 1'b0; bus.pat_in = '0;

    do_reset("rst0");
    do_reset("rst1");
    chk_pat("rst.pattern", bus.pattern, 7'b1111001);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk_pat("rst.cnt", {5'b0, bus.match_cnt}, 7'd0);
`endif

    // single default-pattern match
    stream(32'b1111001, 7, 32'b1000000, "basic");
    do_reset("rstA");

    // overlapping: matches on bits 7 and 13
    bus.overlap = 1'b1;
    stream(32'b1111001111001, 13, 32'b1_0000_0100_0000, "ovl");
    do_reset("rstB");

    // non-overlapping: only bit 7
    bus.overlap = 1'b0;
    stream(32'b1111001111001, 13, 32'b0_0000_0100_0000, "novl");
    do_reset("rstC");
    bus.overlap = 1'b1;

    // idle gap between bits 4 and 5 (x toggled to show it is ignored)
    stream(32'b1111, 4, 32'b0, "gap_a");
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, "gap_idle1");
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "gap_idle2");
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, "gap_idle3");
    stream(32'b001, 3, 32'b100, "gap_b");
    do_reset("rstD");

    // pattern reload mid-stream discards history and the bit on the load cycle
    stream(32'b111100, 6, 32'b0, "rl_pre");
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'b1010101, 1'b0, "rl_load");
    chk_pat("rl.pattern", bus.pattern, 7'b1010101);
    stream(32'b1010101, 7, 32'b1000000, "rl_new");
    do_reset("rstE");
    chk_pat("rstE.pattern", bus.pattern, 7'b1111001);

    // mid-stream reset discards a partial sequence
    stream(32'b11110, 5, 32'b0, "mrst_pre");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, "mrst");
    stream(32'b01, 2, 32'b0, "mrst_post");
    stream(32'b1111001, 7, 32'b1000000, "mrst_full");
    do_reset("rstF");

    // all-ones pattern: 11 ones give 5 overlapping matches
    step(1'b0, 1'b1, 1'b0, 1'b1, 7'b1111111, 1'b0, "ones_load");
    stream(32'b111_1111_1111, 11, 32'b111_1100_0000, "ones");
`ifdef SEQ_DET_MATCH_CNT_EN
    chk_pat("cnt.sat", {5'b0, bus.match_cnt}, 7'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'b1111001, 1'b0, "cnt_load");
    chk_pat("cnt.clr", {5'b0, bus.match_cnt}, 7'd0);
`endif

    chk_bit("queue_drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
